// File: rtl/glyph_pkg.sv
// Shared glyph geometry and loader state encoding for the symbol recogniser
// (bmp_row_loader feeds the bitmap, cmpacc consumes it at GLYPH_BITS width).
package glyph_pkg;

   localparam int GLYPH_ROWS = 64;
   localparam int GLYPH_COLS = 24;
   localparam int GLYPH_BITS = GLYPH_ROWS * GLYPH_COLS;

   typedef logic [GLYPH_COLS-1:0] glyph_row_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      WRITE,
      WAIT_CMP
   } loader_state_e;

endpackage

// File: rtl/bmp_row_loader.sv
// Reads ROWS pixel rows from a 1-cycle-latency memory, packs them row 0 first into
// a flat bitmap and hands it to cmpacc. Build option: BMP_ROW_LOADER_INVERT_EN stores ~rd_data.
module bmp_row_loader
   import glyph_pkg::*;
#(
   parameter int ROWS    = GLYPH_ROWS,
   parameter int COLS    = GLYPH_COLS,
   parameter int AW      = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   input  logic [COLS-1:0]      rd_data,
   output logic [ROWS*COLS-1:0] bitmap,
   output logic                 wren,
   input  logic                 cmp_done,
   output logic                 busy,
   output logic                 err
);

   localparam int BITS = ROWS * COLS;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int TW   = $clog2(TIMEOUT + 1);

   loader_state_e   state_q;
   logic [AW-1:0]   addr_q;
   logic [RW-1:0]   row_q;
   logic [TW-1:0]   tmo_q;
   logic            rd_en_q;
   logic            cap_q;
   logic            wren_q;
   logic            busy_q;
   logic [BITS-1:0] bitmap_q;
   logic [COLS-1:0] row_d;
   logic            tmo_hit;

`ifdef BMP_ROW_LOADER_INVERT_EN
   assign row_d = ~rd_data;
`else
   assign row_d = rd_data;
`endif

   // Timeout is decoded from registered state so that a cmp_done arriving on the
   // very cycle the counter expires still suppresses err.
   assign tmo_hit = (state_q == WAIT_CMP) && (tmo_q == TW'(TIMEOUT));

   // NOTE: all state below uses non-blocking assignments so every register samples
   // the pre-edge values of its peers; blocking here would chain updates within one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         row_q   <= '0;
         tmo_q   <= '0;
         rd_en_q <= 1'b0;
         cap_q   <= 1'b0;
         wren_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cap_q  <= rd_en_q;
         wren_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q  <= base_addr;
                  row_q   <= '0;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (row_q == RW'(ROWS - 1)) begin
                  rd_en_q <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  addr_q <= addr_q + AW'(1);
                  row_q  <= row_q + RW'(1);
               end
            end
            DRAIN: begin
               wren_q  <= 1'b1;
               state_q <= WRITE;
            end
            WRITE: begin
               tmo_q   <= '0;
               state_q <= WAIT_CMP;
            end
            WAIT_CMP: begin
               if (cmp_done || tmo_hit) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            default: begin
               rd_en_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // NOTE: the bitmap is a plain register bank, not a RAM, so it takes the async reset
   // and reads as zero after rst; between loads it only moves on capture cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitmap_q <= '0;
      end else if (cap_q) begin
         bitmap_q <= {bitmap_q[BITS-COLS-1:0], row_d};
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = addr_q;
   assign bitmap  = bitmap_q;
   assign wren    = wren_q;
   assign busy    = busy_q;
   assign err     = tmo_hit && !cmp_done;

endmodule

// File: tb/tb_bmp_row_loader.sv
// Directed bench for bmp_row_loader: table of loads plus reset-in-flight sequence.
// Expectations follow BMP_ROW_LOADER_INVERT_EN when the bench is built with it.
module tb_bmp_row_loader;

   localparam int ROWS    = 64;
   localparam int COLS    = 24;
   localparam int AW      = 16;
   localparam int TIMEOUT = 1023;
   localparam int BITS    = ROWS * COLS;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;
   logic [COLS-1:0] rd_data = '0;
   logic [BITS-1:0] bitmap;
   logic            wren;
   logic            cmp_done = 1'b0;
   logic            busy;
   logic            err;

   int n_pass  = 0;
   int n_total = 0;

   logic [COLS-1:0] mem [0:65535];

   typedef struct {
      logic [AW-1:0]   base;
      int              cmp_delay;   // cycles after wren that cmp_done is raised; -1 = never
      bit              stray;       // fire ignored start pulses while busy
      int              idx_a;
      logic [COLS-1:0] exp_row0;
      logic [COLS-1:0] exp_a;
      logic [COLS-1:0] exp_last;
      bit              exp_err;
   } vec_t;

   vec_t vecs [4];

   bmp_row_loader #(
      .ROWS(ROWS), .COLS(COLS), .AW(AW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .bitmap(bitmap), .wren(wren), .cmp_done(cmp_done),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Memory with fixed 1-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [COLS-1:0] xp(input logic [COLS-1:0] v);
`ifdef BMP_ROW_LOADER_INVERT_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   function automatic logic [COLS-1:0] row_of(input int i);
      return bitmap[BITS-1-COLS*i -: COLS];
   endfunction

   task automatic run_load(input vec_t v, input string tag);
      int bad_fetch, bad_busy, bad_idle, k, err_cnt, err_k;
      bit fin;
      logic [BITS-1:0] snap;
      @(negedge clk);
      start = 1'b1;
      base_addr = v.base;
      @(negedge clk);
      start = 1'b0;
      base_addr = '0;
      bad_fetch = 0;
      for (int i = 0; i < ROWS; i++) begin
         if (rd_en !== 1'b1 || rd_addr !== AW'(32'(v.base) + i) || wren !== 1'b0 || busy !== 1'b1)
            bad_fetch++;
         if (v.stray && i == 10) begin
            start = 1'b1;
            base_addr = 16'h5555;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, "_fetch_seq"}, 64'(bad_fetch), 64'd0);
      check({tag, "_drain"}, {rd_en, wren, busy}, 3'b001);
      @(negedge clk);
      check({tag, "_wren"}, {rd_en, wren, busy}, 3'b011);
      @(negedge clk);
      check({tag, "_wren_drop"}, {rd_en, wren, busy}, 3'b001);
      check({tag, "_row0"}, row_of(0), xp(v.exp_row0));
      check({tag, "_row_a"}, row_of(v.idx_a), xp(v.exp_a));
      check({tag, "_row_last"}, row_of(ROWS - 1), xp(v.exp_last));
      snap = bitmap;

      k = 0;
      fin = 1'b0;
      err_cnt = 0;
      err_k = -1;
      bad_busy = 0;
      while (!fin && k <= TIMEOUT + 8) begin
         if (v.cmp_delay >= 0 && k == v.cmp_delay - 1) begin
            cmp_done = 1'b1;
            if (v.stray) start = 1'b1;
         end else if (v.stray && k == 0) begin
            start = 1'b1;
         end
         #1;
         if (err === 1'b1) begin
            err_cnt++;
            err_k = k;
         end
         if (busy !== 1'b1 || rd_en !== 1'b0 || wren !== 1'b0) bad_busy++;
         if (cmp_done || err === 1'b1) fin = 1'b1;
         @(negedge clk);
         cmp_done = 1'b0;
         start = 1'b0;
         k++;
      end
      check({tag, "_wait_bounded"}, 64'(fin), 64'd1);
      check({tag, "_wait_busy"}, 64'(bad_busy), 64'd0);
      check({tag, "_err_count"}, 64'(err_cnt), 64'(v.exp_err));
      if (v.exp_err) check({tag, "_err_cycle"}, 64'(err_k), 64'(TIMEOUT));
      check({tag, "_busy_fall"}, {busy, err, rd_en, wren}, 4'b0000);
      check({tag, "_frozen"}, 64'(bitmap === snap), 64'd1);
      if (v.stray) begin
         bad_idle = 0;
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (busy !== 1'b0 || rd_en !== 1'b0) bad_idle++;
         end
         check({tag, "_stray_ignored"}, 64'(bad_idle), 64'd0);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [COLS-1:0] pat [ROWS];
      for (int a = 0; a < 65536; a++) mem[a] = {a[7:0] ^ 8'h5A, a[15:0]};
      for (int i = 0; i < ROWS; i++) begin
         if (i == 0 || i == 5 || i == 6 || i >= 62) pat[i] = 24'h000000;
         else if (i <= 2)                          pat[i] = 24'h0000ff;
         else                                      pat[i] = 24'h3fffff;
         mem[16'h0100 + i] = pat[i];
      end

      vecs[0] = '{16'h0100, 5,           1'b1, 1,  24'h000000, 24'h0000ff, 24'h000000, 1'b0};
      vecs[1] = '{16'hFFF0, 5,           1'b0, 16, 24'hAAFFF0, 24'h5A0000, 24'h75002F, 1'b0};
      vecs[2] = '{16'h0100, -1,          1'b0, 3,  24'h000000, 24'h3fffff, 24'h000000, 1'b1};
      vecs[3] = '{16'h0100, TIMEOUT + 1, 1'b0, 61, 24'h000000, 24'h3fffff, 24'h000000, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_ctrl", {rd_en, wren, busy, err}, 4'b0000);
      check("reset_addr", 64'(rd_addr), 64'd0);
      check("reset_bitmap", 64'(bitmap === '0), 64'd1);
      rst = 1'b0;

      for (int n = 0; n < 4; n++) run_load(vecs[n], $sformatf("vec%0d", n));

      // Reset while row 30 is being fetched.
      @(negedge clk);
      start = 1'b1;
      base_addr = 16'h0100;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      check("midrst_pre_rd_en", {rd_en, busy}, 2'b11);
      #2 rst = 1'b1;
      #1;
      check("midrst_ctrl", {rd_en, wren, busy, err}, 4'b0000);
      check("midrst_bitmap", 64'(bitmap === '0), 64'd1);
      @(negedge clk);
      check("midrst_no_wren", {rd_en, wren, busy}, 3'b000);
      rst = 1'b0;
      run_load(vecs[0], "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bmp_row_loader.md
Name: bmp_row_loader

Overview:
- Upstream feeder for the compare/accumulate stage (cmpacc) of the symbol recogniser.
- On a start pulse, reads ROWS consecutive COLS-bit pixel rows from image memory through a fixed 1-cycle-latency read port and packs them into the flat ROWS*COLS bitmap bus.
- Pulses wren for one cycle to hand the bitmap to cmpacc.
- Holds the bitmap stable until cmpacc signals done, or until a timeout expires.

Parameters:
- ROWS, 64, rows per glyph window.
- COLS, 24, pixels per row.
- AW, 16, memory address width.
- TIMEOUT, 1023, max cycles in WAIT_CMP before err.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- base_addr  in  AW  address of row 0; sampled with start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  AW  memory read address.
- rd_data  in  COLS  row data, valid the cycle after rd_en.
- bitmap  out  ROWS*COLS  packed window; row 0 in the MSBs [ROWS*COLS-1 -: COLS], row ROWS-1 in the LSBs.
- wren  out  1  one-cycle strobe to cmpacc; bitmap is complete and stable.
- cmp_done  in  1  cmpacc done/result-valid.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on cmp_done timeout.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: all outputs 0, bitmap 0, state IDLE, counters 0.
- IDLE:
  - On start, latch base_addr into the address counter, clear the row counter, go to FETCH.
  - start while busy is ignored (no queueing).
- FETCH:
  - rd_en=1 for exactly ROWS consecutive cycles.
  - rd_addr = base_addr + i for i = 0..ROWS-1, modulo 2^AW (wraps 0xFFFF->0x0000 silently).
  - Leave to DRAIN after issuing row ROWS-1.
- Capture:
  - Each cycle after an rd_en cycle, bitmap <= {bitmap[ROWS*COLS-COLS-1:0], rd_data} (shift left by COLS).
  - After ROWS captures, row 0 sits in the MSBs.
- DRAIN: one cycle; captures the last row; go to WRITE.
- WRITE: wren=1 for one cycle; go to WAIT_CMP.
- Latency: start at cycle T gives rd_en at T+1..T+ROWS, last capture at T+ROWS+1, wren at T+ROWS+2.
- WAIT_CMP:
  - bitmap frozen. The timeout counter increments each cycle.
  - cmp_done=1 -> IDLE (busy falls the next cycle).
  - If the counter reaches TIMEOUT with no cmp_done, pulse err for one cycle -> IDLE.
  - cmp_done in the same cycle as the timeout: done wins, no err.
  - cmp_done outside WAIT_CMP is ignored.
- bitmap is not cleared between loads; it changes only during capture cycles.
- Mid-operation reset: immediate return to IDLE with all outputs 0. rd_en and wren drop asynchronously; no partial wren is ever produced.
- Back-to-back: start in the same cycle busy falls is ignored; the earliest accepted start is the first cycle with busy=0.

Optional Feature:
- Macro: BMP_ROW_LOADER_INVERT_EN.
- Defined: each captured row is stored as ~rd_data, for memories that store ink as 0.
- Undefined: rd_data is stored unmodified.
- Timing, ports and every other behaviour are identical in both builds.

Decomposition:
- Shared package glyph_pkg holds:
  - GLYPH_ROWS=64 and GLYPH_COLS=24 (parameter defaults).
  - GLYPH_BITS=GLYPH_ROWS*GLYPH_COLS.
  - typedef glyph_row_t = logic[GLYPH_COLS-1:0].
  - loader state enum {IDLE, FETCH, DRAIN, WRITE, WAIT_CMP}.
- cmpacc uses the same package for its bitmap width.
- No sub-module. FSM, address counter, shift register and timeout counter live in one module.

Test Plan:
- Memory rows 0..63 = 24'h000000, 24'h0000ff x2, 24'h3fffff x2, 24'h000000 x2, 24'h3fffff x55, 24'h000000 x2; start with base 0x0100 -> rd_addr 0x0100..0x013F on 64 consecutive cycles; wren exactly 1 cycle at T+66; bitmap[1535:1512]=24'h000000, bitmap[1511:1488]=24'h0000ff, bitmap[23:0]=24'h000000.
- base_addr=0xFFF0 -> rd_addr sequence 0xFFF0..0xFFFF then 0x0000..0x002F; bitmap order correct.
- cmp_done asserted 5 cycles after wren -> busy falls the next cycle; no err. A second start while busy has no effect: rd_en stays low and the rd_addr sequence is unchanged.
- cmp_done never asserted -> err pulses once, TIMEOUT cycles after WAIT_CMP entry; busy=0 next cycle. With cmp_done on the timeout cycle: no err.
- rst asserted at row 30 of FETCH -> rd_en, wren, busy and bitmap are 0 asynchronously; a fresh start then produces a full 64-row load.
- Build with BMP_ROW_LOADER_INVERT_EN, memory row 0 = 24'h0000ff -> bitmap[1535:1512]=24'hffff00.
